// File: rtl/prio_encoder.sv
// Priority encoder: reduces a WIDTH-bit request vector to the index of the
// winning set bit, with a valid flag and a one-hot copy of the winner.
//
// Parameters:
//   WIDTH             number of request bits (>= 1)
//   LSB_HIGH_PRIORITY 0: highest set index wins, 1: lowest set index wins
//   REGISTER_OUTPUT   0: combinational outputs, 1: one-cycle registered outputs
// Ports:
//   clk              clock (used only when REGISTER_OUTPUT=1)
//   rst              synchronous active-high reset of the output register
//   input_unencoded  request vector, bit i = candidate i matches
//   output_valid     at least one request bit set
//   output_encoded   winner index (0 when nothing is set)
//   output_unencoded one-hot winner (0 when nothing is set)
module prio_encoder #(
    parameter int WIDTH             = 4,
    parameter int LSB_HIGH_PRIORITY = 0,
    parameter int REGISTER_OUTPUT   = 0,
    localparam int EW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] input_unencoded,
    output logic             output_valid,
    output logic [EW-1:0]    output_encoded,
    output logic [WIDTH-1:0] output_unencoded
);

    localparam int PW = 1 << EW;

    // Heap-ordered tree: node k merges children 2k (lower indices) and
    // 2k+1 (upper indices); leaves sit at PW..2*PW-1 and node 1 is the root.
    // Each node carries the full leaf position of its local winner.
    logic [PW-1:0] req_pad;
    logic          vld [1:2*PW-1];
    logic [EW-1:0] pos [1:2*PW-1];

    always_comb begin
        req_pad = '0;
        req_pad[WIDTH-1:0] = input_unencoded;
    end

    for (genvar i = 0; i < PW; i++) begin : g_leaf
        assign vld[PW+i] = req_pad[i];
        assign pos[PW+i] = EW'(i);
    end

    for (genvar k = 1; k < PW; k++) begin : g_node
        logic take_hi;
        if (LSB_HIGH_PRIORITY != 0) begin : g_lsb
            assign take_hi = !vld[2*k];
        end else begin : g_msb
            assign take_hi = vld[2*k+1];
        end
        assign vld[k] = vld[2*k] | vld[2*k+1];
        assign pos[k] = take_hi ? pos[2*k+1] : pos[2*k];
    end

    logic             nxt_valid;
    logic [EW-1:0]    nxt_encoded;
    logic [WIDTH-1:0] nxt_unencoded;

    // With no request the tree may still steer toward a padded leaf, so the
    // index is forced to zero unless the root is valid.
    always_comb begin
        nxt_valid     = vld[1];
        nxt_encoded   = vld[1] ? pos[1] : '0;
        nxt_unencoded = '0;
        for (int i = 0; i < WIDTH; i++) begin
            nxt_unencoded[i] = vld[1] && (pos[1] == EW'(i));
        end
    end

    if (REGISTER_OUTPUT != 0) begin : g_reg
        always_ff @(posedge clk) begin
            if (rst) begin
                output_valid     <= 1'b0;
                output_encoded   <= '0;
                output_unencoded <= '0;
            end else begin
                output_valid     <= nxt_valid;
                output_encoded   <= nxt_encoded;
                output_unencoded <= nxt_unencoded;
            end
        end
    end else begin : g_comb
        assign output_valid     = nxt_valid;
        assign output_encoded   = nxt_encoded;
        assign output_unencoded = nxt_unencoded;
    end

endmodule

// File: tb/tb_prio_encoder.sv
// Testbench for prio_encoder: table-driven WIDTH=8 vectors, WIDTH=5 walk and
// sweep, exhaustive WIDTH=4/3, WIDTH=1, and registered-output sequences.
module tb_prio_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in8 = 8'hFF;
    logic [4:0] in5 = '0;
    logic [3:0] in4 = '0;
    logic [2:0] in3 = '0;
    logic [0:0] in1 = '0;

    always #5 clk = ~clk;

    logic       v8m, v8l, v8r, v5, v4m, v4l, v3m, v3l, v1;
    logic [2:0] e8m, e8l, e8r, e5;
    logic [1:0] e4m, e4l, e3m, e3l;
    logic [0:0] e1;
    logic [7:0] u8m, u8l, u8r;
    logic [4:0] u5;
    logic [3:0] u4m, u4l;
    logic [2:0] u3m, u3l;
    logic [0:0] u1;

    prio_encoder #(.WIDTH(8)) d8m (.clk(clk), .rst(rst), .input_unencoded(in8),
        .output_valid(v8m), .output_encoded(e8m), .output_unencoded(u8m));
    prio_encoder #(.WIDTH(8), .LSB_HIGH_PRIORITY(1)) d8l (.clk(clk), .rst(rst),
        .input_unencoded(in8), .output_valid(v8l), .output_encoded(e8l),
        .output_unencoded(u8l));
    prio_encoder #(.WIDTH(8), .REGISTER_OUTPUT(1)) d8r (.clk(clk), .rst(rst),
        .input_unencoded(in8), .output_valid(v8r), .output_encoded(e8r),
        .output_unencoded(u8r));
    prio_encoder #(.WIDTH(5)) d5 (.clk(clk), .rst(rst), .input_unencoded(in5),
        .output_valid(v5), .output_encoded(e5), .output_unencoded(u5));
    prio_encoder #(.WIDTH(4)) d4m (.clk(clk), .rst(rst), .input_unencoded(in4),
        .output_valid(v4m), .output_encoded(e4m), .output_unencoded(u4m));
    prio_encoder #(.WIDTH(4), .LSB_HIGH_PRIORITY(1)) d4l (.clk(clk), .rst(rst),
        .input_unencoded(in4), .output_valid(v4l), .output_encoded(e4l),
        .output_unencoded(u4l));
    prio_encoder #(.WIDTH(3)) d3m (.clk(clk), .rst(rst), .input_unencoded(in3),
        .output_valid(v3m), .output_encoded(e3m), .output_unencoded(u3m));
    prio_encoder #(.WIDTH(3), .LSB_HIGH_PRIORITY(1)) d3l (.clk(clk), .rst(rst),
        .input_unencoded(in3), .output_valid(v3l), .output_encoded(e3l),
        .output_unencoded(u3l));
    prio_encoder #(.WIDTH(1)) d1 (.clk(clk), .rst(rst), .input_unencoded(in1),
        .output_valid(v1), .output_encoded(e1), .output_unencoded(u1));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: scan every bit; highest wins unless lsb, then first wins.
    function automatic int ref_enc(input int v, input int w, input bit lsb);
        int  r     = 0;
        bit  found = 0;
        for (int i = 0; i < w; i++) begin
            if (v[i]) begin
                if (!lsb) r = i;
                else if (!found) r = i;
                found = 1;
            end
        end
        return r;
    endfunction

    function automatic int ref_oh(input int v, input int w, input bit lsb);
        int m = (1 << w) - 1;
        if ((v & m) == 0) return 0;
        return 1 << ref_enc(v, w, lsb);
    endfunction

    typedef struct {
        logic [7:0] in;
        logic       v;
        logic [2:0] em;
        logic [2:0] el;
    } vec_t;

    vec_t tbl [8];

    initial begin
        tbl[0] = '{8'b0010_0110, 1'b1, 3'd5, 3'd1};
        tbl[1] = '{8'h00, 1'b0, 3'd0, 3'd0};
        tbl[2] = '{8'hFF, 1'b1, 3'd7, 3'd0};
        tbl[3] = '{8'h80, 1'b1, 3'd7, 3'd7};
        tbl[4] = '{8'h01, 1'b1, 3'd0, 3'd0};
        tbl[5] = '{8'h24, 1'b1, 3'd5, 3'd2};
        tbl[6] = '{8'h18, 1'b1, 3'd4, 3'd3};
        tbl[7] = '{8'h42, 1'b1, 3'd6, 3'd1};

        // Registered instance held in reset while input is all ones.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(v8r), 32'd0);
        chk("rst_enc", 32'(e8r), 32'd0);
        chk("rst_oh", 32'(u8r), 32'd0);

        // WIDTH=8 table, both priorities (rst high must not matter here).
        foreach (tbl[i]) begin
            logic [7:0] om, ol;
            in8 = tbl[i].in;
            #1;
            om = tbl[i].v ? (8'd1 << tbl[i].em) : 8'd0;
            ol = tbl[i].v ? (8'd1 << tbl[i].el) : 8'd0;
            chk($sformatf("w8m_valid[%0d]", i), 32'(v8m), 32'(tbl[i].v));
            chk($sformatf("w8m_enc[%0d]", i), 32'(e8m), 32'(tbl[i].em));
            chk($sformatf("w8m_oh[%0d]", i), 32'(u8m), 32'(om));
            chk($sformatf("w8l_valid[%0d]", i), 32'(v8l), 32'(tbl[i].v));
            chk($sformatf("w8l_enc[%0d]", i), 32'(e8l), 32'(tbl[i].el));
            chk($sformatf("w8l_oh[%0d]", i), 32'(u8l), 32'(ol));
        end

        // WIDTH=5: hand vector, walking one, random sweep.
        in5 = 5'b10001;
        #1;
        chk("w5_enc_10001", 32'(e5), 32'd4);
        chk("w5_oh_10001", 32'(u5), 32'b10000);
        for (int i = 0; i < 5; i++) begin
            in5 = 5'd1 << i;
            #1;
            chk($sformatf("w5_walk_enc[%0d]", i), 32'(e5), 32'(i));
            chk($sformatf("w5_walk_oh[%0d]", i), 32'(u5), 32'(1 << i));
            chk($sformatf("w5_walk_v[%0d]", i), 32'(v5), 32'd1);
        end
        for (int i = 0; i < 40; i++) begin
            int r;
            r = int'($urandom_range(0, 31));
            in5 = 5'(r);
            #1;
            chk($sformatf("w5_rnd_v[%0h]", r), 32'(v5), 32'(r != 0));
            chk($sformatf("w5_rnd_enc[%0h]", r), 32'(e5), 32'(ref_enc(r, 5, 0)));
            chk($sformatf("w5_rnd_oh[%0h]", r), 32'(u5), 32'(ref_oh(r, 5, 0)));
        end

        // Exhaustive WIDTH=4 and WIDTH=3, both priorities.
        for (int p = 0; p < 16; p++) begin
            in4 = 4'(p);
            #1;
            chk($sformatf("w4m_v[%0h]", p), 32'(v4m), 32'(p != 0));
            chk($sformatf("w4m_enc[%0h]", p), 32'(e4m), 32'(ref_enc(p, 4, 0)));
            chk($sformatf("w4m_oh[%0h]", p), 32'(u4m), 32'(ref_oh(p, 4, 0)));
            chk($sformatf("w4l_v[%0h]", p), 32'(v4l), 32'(p != 0));
            chk($sformatf("w4l_enc[%0h]", p), 32'(e4l), 32'(ref_enc(p, 4, 1)));
            chk($sformatf("w4l_oh[%0h]", p), 32'(u4l), 32'(ref_oh(p, 4, 1)));
            chk($sformatf("w4m_pop[%0h]", p), 32'($countones(u4m)), 32'(p != 0));
            chk($sformatf("w4l_pop[%0h]", p), 32'($countones(u4l)), 32'(p != 0));
            if (p != 0) begin
                chk($sformatf("w4m_sel[%0h]", p), 32'(u4m[e4m]), 32'd1);
                chk($sformatf("w4l_sel[%0h]", p), 32'(u4l[e4l]), 32'd1);
            end
        end
        for (int p = 0; p < 8; p++) begin
            in3 = 3'(p);
            #1;
            chk($sformatf("w3m_v[%0h]", p), 32'(v3m), 32'(p != 0));
            chk($sformatf("w3m_enc[%0h]", p), 32'(e3m), 32'(ref_enc(p, 3, 0)));
            chk($sformatf("w3m_oh[%0h]", p), 32'(u3m), 32'(ref_oh(p, 3, 0)));
            chk($sformatf("w3l_v[%0h]", p), 32'(v3l), 32'(p != 0));
            chk($sformatf("w3l_enc[%0h]", p), 32'(e3l), 32'(ref_enc(p, 3, 1)));
            chk($sformatf("w3l_oh[%0h]", p), 32'(u3l), 32'(ref_oh(p, 3, 1)));
            chk($sformatf("w3m_pop[%0h]", p), 32'($countones(u3m)), 32'(p != 0));
            chk($sformatf("w3l_pop[%0h]", p), 32'($countones(u3l)), 32'(p != 0));
            if (p != 0) begin
                chk($sformatf("w3m_sel[%0h]", p), 32'(u3m[e3m]), 32'd1);
                chk($sformatf("w3l_sel[%0h]", p), 32'(u3l[e3l]), 32'd1);
            end
        end

        // WIDTH=1.
        for (int p = 0; p < 2; p++) begin
            in1 = 1'(p);
            #1;
            chk($sformatf("w1_v[%0d]", p), 32'(v1), 32'(p));
            chk($sformatf("w1_enc[%0d]", p), 32'(e1), 32'd0);
            chk($sformatf("w1_oh[%0d]", p), 32'(u1), 32'(p));
        end

        // Registered outputs: one-cycle latency, back-to-back inputs.
        @(negedge clk);
        rst = 1'b0;
        in8 = 8'h24;
        @(posedge clk);
        #1;
        chk("reg_enc_24", 32'(e8r), 32'd5);
        chk("reg_valid_24", 32'(v8r), 32'd1);
        chk("reg_oh_24", 32'(u8r), 32'h20);
        in8 = 8'h01;
        #1;
        chk("reg_hold_enc", 32'(e8r), 32'd5);
        chk("reg_hold_oh", 32'(u8r), 32'h20);
        @(posedge clk);
        #1;
        chk("reg_enc_01", 32'(e8r), 32'd0);
        chk("reg_valid_01", 32'(v8r), 32'd1);
        chk("reg_oh_01", 32'(u8r), 32'h01);

        // Reset beats a live input, then release loads normally.
        @(negedge clk);
        rst = 1'b1;
        in8 = 8'hFF;
        @(posedge clk);
        #1;
        chk("reg_rst_valid", 32'(v8r), 32'd0);
        chk("reg_rst_enc", 32'(e8r), 32'd0);
        chk("reg_rst_oh", 32'(u8r), 32'd0);
        chk("comb_during_rst", 32'(e8m), 32'd7);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("reg_rel_enc", 32'(e8r), 32'd7);
        chk("reg_rel_valid", 32'(v8r), 32'd1);
        chk("reg_rel_oh", 32'(u8r), 32'h80);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
